bus_region_router: RTL and testbench
====================================

// Module: bus_region_router
// PURPOSE
//  Parametrised N-region address decoder and request router between one bus master (core LSU)
//  and NUM_SLAVES targets (RAM, IO, ...). Each accepted request is decoded against a
//  base/mask table and forwarded to exactly one slave. The block holds the transaction until
//  that slave acks or a timeout expires. Unmapped addresses get an error response.
// PARAMETERS
//  NUM_SLAVES   2                          number of target regions/slaves (1..8)
//  ADDR_W       32                         address width
//  DATA_W       32                         data width
//  REGION_BASE  {32'hF000_0000,32'h0}      packed NUM_SLAVES*ADDR_W; slave i base in slice i
//  REGION_MASK  {32'hFFFF_0000,32'hF000_0000} packed; hit_i = (addr & MASK_i) == BASE_i
//  TIMEOUT      255                        max cycles waiting for slave ack (>=2)
// PORTS
//  clk          in   1                  clock, all logic rising-edge
//  rst_n        in   1                  asynchronous active-low reset
//  m_req_i      in   1                  master request; accepted only when m_ready_o=1
//  m_we_i       in   1                  1=write, 0=read
//  m_addr_i     in   ADDR_W             request address
//  m_wdata_i    in   DATA_W             write data
//  m_ready_o    out  1                  router idle, can accept a request
//  m_ack_o      out  1                  one-cycle response pulse
//  m_err_o      out  1                  qualifies m_ack_o: unmapped address or timeout
//  m_rdata_o    out  DATA_W             read data, valid with m_ack_o (0 on error/write)
//  s_req_o      out  NUM_SLAVES         one-hot request to selected slave, held until ack
//  s_we_o       out  1                  latched m_we_i, broadcast to all slaves
//  s_addr_o     out  ADDR_W             latched address, broadcast
//  s_wdata_o    out  DATA_W             latched write data, broadcast
//  s_ack_i      in   NUM_SLAVES         per-slave ack; only the selected bit is honoured
//  s_rdata_i    in   NUM_SLAVES*DATA_W  per-slave read data, slice i for slave i
// BEHAVIOUR
//  - Reset: state=IDLE; m_ready_o=1; m_ack_o, m_err_o, s_req_o, s_we_o=0; all data/addr regs=0.
//    Reset mid-transaction aborts it silently. No response is issued.
//  - All outputs are registered. FSM states are IDLE, ACCESS and RESP.
//  - IDLE: on m_req_i, latch we/addr/wdata into s_*_o and drop m_ready_o.
//    Decode with priority to the lowest-index region when regions overlap.
//    Hit region k: s_req_o <= one-hot(k), timer <= 0, go to ACCESS (s_req_o high at cycle +1).
//    Miss: m_ack_o <= 1, m_err_o <= 1, m_rdata_o <= 0, go to RESP (response at cycle +1).
//  - ACCESS: the timer increments each cycle.
//    s_ack_i[k]=1: s_req_o <= 0, m_ack_o <= 1, m_err_o <= 0,
//      m_rdata_o <= we ? 0 : s_rdata_i[k], go to RESP. Minimum hit latency: req to m_ack_o = 2 cycles.
//    Else if timer == TIMEOUT-1: s_req_o <= 0, m_ack_o <= 1, m_err_o <= 1, m_rdata_o <= 0, go to RESP.
//    If ack and timeout coincide, the ack wins. Acks from non-selected slaves are ignored.
//  - RESP: m_ack_o <= 0, m_err_o <= 0, m_ready_o <= 1, go to IDLE.
//    Back-to-back requests are spaced by at least 1 idle cycle after m_ack_o.
//  - m_req_i while m_ready_o=0 is ignored, not queued.
//  - Timer is $clog2(TIMEOUT+1) bits wide and never wraps; it saturates via the timeout exit.
// TESTING
//  1 RAM read: req addr 0x0000_1000, slave0 acks with rdata 0xDEADBEEF 3 cycles after s_req_o[0]
//    -> single m_ack_o, rdata 0xDEADBEEF, err=0, s_req_o=2'b01 during the wait.
//  2 IO write: addr 0xF000_0004, wdata 0x55, we=1, slave1 acks immediately
//    -> s_req_o=2'b10 for 1 cycle, s_wdata_o=0x55, m_ack_o at req+2, rdata=0.
//  3 Unmapped: addr 0x8000_0000 -> m_ack_o=1, m_err_o=1 at req+1, s_req_o stays 0.
//  4 Timeout: addr 0xF000_0010, slave never acks, TIMEOUT=8
//    -> s_req_o[1] high 8 cycles, then m_ack_o with m_err_o=1. Stray s_ack_i[0] pulses are ignored.
//  5 Ack on the final timeout cycle -> ack wins, err=0. m_req_i pulsed during ACCESS -> no effect.
//  6 rst_n low during ACCESS -> s_req_o=0 and m_ready_o=1 immediately (async), no m_ack_o.
//    Next request after reset completes normally.

Source files
------------

// File: rtl/bus_region_router_if.sv
// Bus bundle between the LSU master, the router and its target slaves.
// Handshake: the master raises m_req_i; it is taken only in a cycle where m_ready_o=1.
// The router answers with exactly one m_ack_o pulse. A slave sees s_req_o held high
// until it returns one s_ack_i pulse or the router gives up.
interface bus_region_router_if #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                         m_req_i;
  logic                         m_we_i;
  logic [ADDR_W-1:0]            m_addr_i;
  logic [DATA_W-1:0]            m_wdata_i;
  logic                         m_ready_o;
  logic                         m_ack_o;
  logic                         m_err_o;
  logic [DATA_W-1:0]            m_rdata_o;
  logic [NUM_SLAVES-1:0]        s_req_o;
  logic                         s_we_o;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [DATA_W-1:0]            s_wdata_o;
  logic [NUM_SLAVES-1:0]        s_ack_i;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i;

  // The router view: it acts as the slave of the LSU and drives the target request lines.
  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    output m_ready_o, m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o
  );

  // The environment view: the LSU plus all target slaves.
  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    input  m_ready_o, m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o
  );
endinterface

// File: rtl/bus_region_router.sv
// Base/mask address decoder routing one master request to a single slave.
// The transaction is held until that slave acks or a timeout expires.
module bus_region_router #(
  parameter int                            NUM_SLAVES  = 2,
  parameter int                            ADDR_W      = 32,
  parameter int                            DATA_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_BASE = {32'hF000_0000, 32'h0},
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  REGION_MASK = {32'hFFFF_0000, 32'hF000_0000},
  parameter int                            TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_region_router_if.slave   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  state_t                  state, state_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic                    ready_nxt, ack_nxt, err_nxt, we_nxt;
  logic [DATA_W-1:0]       rdata_nxt, wdata_nxt;
  logic [ADDR_W-1:0]       addr_nxt;
  logic [NUM_SLAVES-1:0]   sreq_nxt;

  logic [NUM_SLAVES-1:0]   hit_oh;
  logic                    hit_any;
  logic                    sel_ack;
  logic [DATA_W-1:0]       sel_rdata;

  // Scanning downwards lets the lowest-index region win when regions overlap.
  always_comb begin
    hit_oh  = '0;
    hit_any = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_oh  = NUM_SLAVES'(1) << i;
        hit_any = 1'b1;
      end
    end
  end

  assign sel_ack = |(bus.s_ack_i & bus.s_req_o);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (bus.s_req_o[i]) sel_rdata = sel_rdata | bus.s_rdata_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      bus.m_ready_o <= 1'b1;
      bus.m_ack_o   <= 1'b0;
      bus.m_err_o   <= 1'b0;
      bus.m_rdata_o <= '0;
      bus.s_req_o   <= '0;
      bus.s_we_o    <= 1'b0;
      bus.s_addr_o  <= '0;
      bus.s_wdata_o <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      bus.m_ready_o <= ready_nxt;
      bus.m_ack_o   <= ack_nxt;
      bus.m_err_o   <= err_nxt;
      bus.m_rdata_o <= rdata_nxt;
      bus.s_req_o   <= sreq_nxt;
      bus.s_we_o    <= we_nxt;
      bus.s_addr_o  <= addr_nxt;
      bus.s_wdata_o <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.m_req_i) state_nxt = hit_any ? ACCESS : RESP;
      ACCESS:  if (sel_ack || timer == T_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    timer_nxt = timer;
    ready_nxt = bus.m_ready_o;
    ack_nxt   = bus.m_ack_o;
    err_nxt   = bus.m_err_o;
    rdata_nxt = bus.m_rdata_o;
    sreq_nxt  = bus.s_req_o;
    we_nxt    = bus.s_we_o;
    addr_nxt  = bus.s_addr_o;
    wdata_nxt = bus.s_wdata_o;
    case (state)
      IDLE: begin
        if (bus.m_req_i) begin
          ready_nxt = 1'b0;
          we_nxt    = bus.m_we_i;
          addr_nxt  = bus.m_addr_i;
          wdata_nxt = bus.m_wdata_i;
          if (hit_any) begin
            sreq_nxt  = hit_oh;
            timer_nxt = '0;
          end else begin
            ack_nxt   = 1'b1;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
          end
        end
      end
      ACCESS: begin
        // Exits at TIMEOUT-1, so the timer tops out at TIMEOUT and never wraps.
        timer_nxt = timer + TW'(1);
        if (sel_ack) begin
          sreq_nxt  = '0;
          ack_nxt   = 1'b1;
          err_nxt   = 1'b0;
          rdata_nxt = bus.s_we_o ? '0 : sel_rdata;
        end else if (timer == T_LAST) begin
          sreq_nxt  = '0;
          ack_nxt   = 1'b1;
          err_nxt   = 1'b1;
          rdata_nxt = '0;
        end
      end
      RESP: begin
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        ready_nxt = 1'b1;
      end
      default: begin
        ready_nxt = 1'b1;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        sreq_nxt  = '0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bus_region_router.sv
// Randomised bench for bus_region_router: a driver plays master and slaves, a monitor
// pops expected responses (latency, err, rdata) from a queue on every m_ack_o.
module tb_bus_region_router;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int EW = 16 + 1 + DW;
  localparam logic [NS*AW-1:0] BASE = {32'hF000_0000, 32'h0};
  localparam logic [NS*AW-1:0] MASK = {32'hFFFF_0000, 32'hF000_0000};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         issue_cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [EW-1:0] exp_q[$];

  bus_region_router_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus();

  bus_region_router #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .REGION_BASE(BASE), .REGION_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference decode: first region (lowest index) whose masked address equals its base.
  function automatic int region_of(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.m_ack_o) begin
      logic [EW-1:0] e, got;
      got = {16'(cyc - issue_cyc), bus.m_err_o, bus.m_rdata_o};
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 64'(got), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp{lat,err,rdata}", 64'(got), 64'(e));
      end
    end
  end

  // delay: index of the s_req_o cycle in which the selected slave acks (>=TO means never).
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int delay, input bit do_reset, input int reset_at);
    int k, w, n_req, exp_req;
    logic [NS-1:0] oh, ack;
    bit hit_reset;
    w = 0;
    while (!bus.m_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.m_ready_o) chk("ready_wait", 64'(bus.m_ready_o), 64'd1);
    for (int i = 0; i < NS; i++) bus.s_rdata_i[i*DW +: DW] = $urandom();
    k  = region_of(addr);
    oh = (k >= 0) ? NS'(1) << k : '0;
    bus.m_req_i   = 1'b1;
    bus.m_we_i    = we;
    bus.m_addr_i  = addr;
    bus.m_wdata_i = wdata;
    issue_cyc     = cyc;
    if (!do_reset) begin
      if (k < 0)             exp_q.push_back({16'd1, 1'b1, {DW{1'b0}}});
      else if (delay <= TO-1) exp_q.push_back({16'(delay + 2), 1'b0, we ? {DW{1'b0}} : bus.s_rdata_i[k*DW +: DW]});
      else                   exp_q.push_back({16'(TO + 1), 1'b1, {DW{1'b0}}});
    end
    @(negedge clk);
    bus.m_req_i = 1'b0;
    chk("s_addr_latch", 64'(bus.s_addr_o), 64'(addr));
    chk("s_we_latch", 64'(bus.s_we_o), 64'(we));
    chk("s_wdata_latch", 64'(bus.s_wdata_o), 64'(wdata));
    chk("ready_low", 64'(bus.m_ready_o), 64'd0);
    n_req = 0;
    hit_reset = 1'b0;
    for (int j = 0; j < TO + 4 && bus.s_req_o != '0; j++) begin
      chk("s_req_onehot", 64'(bus.s_req_o), 64'(oh));
      n_req++;
      ack = NS'($urandom()) & ~oh;
      if (j == delay && k >= 0) ack = ack | oh;
      bus.s_ack_i  = ack;
      bus.m_req_i  = 1'($urandom_range(0, 1));
      bus.m_addr_i = $urandom();
      if (do_reset && j == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_s_req", 64'(bus.s_req_o), 64'd0);
        chk("rst_ready", 64'(bus.m_ready_o), 64'd1);
        chk("rst_ack", 64'(bus.m_ack_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hit_reset = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.s_ack_i = '0;
    bus.m_req_i = 1'b0;
    if (!do_reset) begin
      exp_req = (k < 0) ? 0 : ((delay + 1 < TO) ? delay + 1 : TO);
      chk("s_req_cycles", 64'(n_req), 64'(exp_req));
    end else begin
      chk("reset_reached", 64'(hit_reset), 64'd1);
    end
  endtask

  initial begin
    bus.m_req_i   = 1'b0;
    bus.m_we_i    = 1'b0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
    bus.s_ack_i   = '0;
    bus.s_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bus.m_ready_o), 64'd1);
    chk("reset_ack", 64'(bus.m_ack_o), 64'd0);
    chk("reset_err", 64'(bus.m_err_o), 64'd0);
    chk("reset_rdata", 64'(bus.m_rdata_o), 64'd0);
    chk("reset_s_req", 64'(bus.s_req_o), 64'd0);
    chk("reset_s_we", 64'(bus.s_we_o), 64'd0);
    chk("reset_s_addr", 64'(bus.s_addr_o), 64'd0);
    chk("reset_s_wdata", 64'(bus.s_wdata_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 32'h0000_1000, 32'h0, 3, 1'b0, 0);        // RAM read, ack after 3 cycles
    run_txn(1'b1, 32'hF000_0004, 32'h55, 0, 1'b0, 0);       // IO write, immediate ack
    run_txn(1'b0, 32'h8000_0000, 32'h0, 0, 1'b0, 0);        // unmapped
    run_txn(1'b0, 32'hF000_0010, 32'h0, 100, 1'b0, 0);      // timeout
    run_txn(1'b0, 32'h0000_2000, 32'h0, TO - 1, 1'b0, 0);   // ack on final cycle wins
    run_txn(1'b1, 32'h0000_3000, 32'h77, 100, 1'b1, 3);     // reset mid-access
    run_txn(1'b0, 32'h0000_1004, 32'h0, 1, 1'b0, 0);        // normal after reset

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = $urandom();
      case ($urandom_range(0, 2))
        0:       a = a & 32'h0FFF_FFFF;
        1:       a = {16'hF000, a[15:0]};
        default: a = {4'(8 + $urandom_range(0, 6)), a[27:0]};
      endcase
      run_txn(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, TO + 2), 1'b0, 0);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
